// File: rtl/frame_buffer_pkg.sv
// Constants and state encoding shared by the frame-buffer RAM and its write scheduler.
package frame_buffer_pkg;

  localparam int FB_AW    = 15;
  localparam int FB_DW    = 12;
  localparam int IMA_W    = 160;
  localparam int IMA_H    = 120;
  localparam int IMA_SIZE = IMA_W * IMA_H;

  // Word read by the VGA side for out-of-image positions; never overwritten.
  localparam int                BLACK_ADDR  = IMA_SIZE;
  localparam logic [FB_DW-1:0]  BLACK_PIXEL = 12'h000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DONE
  } clr_state_e;

endpackage

// File: rtl/clear_addr_gen.sv
// Frame-clear address counter: counts 0..LAST under enable, holds at LAST
// (terminal count) and restarts from 0 on a synchronous clear.
module clear_addr_gen
  import frame_buffer_pkg::*;
#(
  parameter int AW   = FB_AW,
  parameter int LAST = IMA_SIZE - 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [AW-1:0] o_ptr,
  output logic          o_tc
);

  localparam logic [AW-1:0] LP_LAST = AW'(LAST);

  logic [AW-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_en && !o_tc) begin
      r_ptr <= r_ptr + AW'(1);
    end
  end

  assign o_ptr = r_ptr;
  assign o_tc  = (r_ptr == LP_LAST);

endmodule

// File: rtl/buffer_write_scheduler.sv
// Shares the frame-buffer RAM write port between the camera (never stalled)
// and the frame-clear engine, and drops camera writes at or above the image.
module buffer_write_scheduler #(
  parameter int AW       = frame_buffer_pkg::FB_AW,
  parameter int DW       = frame_buffer_pkg::FB_DW,
  parameter int IMA_SIZE = frame_buffer_pkg::IMA_SIZE
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cam_we,
  input  logic [AW-1:0] cam_addr,
  input  logic [DW-1:0] cam_data,
  input  logic          clr_start,
  input  logic [DW-1:0] clr_color,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          oob_flag,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data
);

  import frame_buffer_pkg::clr_state_e;
  import frame_buffer_pkg::ST_IDLE;
  import frame_buffer_pkg::ST_CLEAR;
  import frame_buffer_pkg::ST_DONE;

  localparam logic [AW-1:0] LP_LIMIT = AW'(IMA_SIZE);

  clr_state_e    r_state;
  logic [DW-1:0] r_color_q;
  logic          r_clr_busy;
  logic          r_clr_done;
  logic          r_oob_flag;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_data;

  logic [AW-1:0] w_ptr;
  logic          w_tc;
  logic          w_cam_in_range;
  logic          w_clr_we;
  logic          w_ptr_clr;

  assign w_cam_in_range = (cam_addr < LP_LIMIT);
  // Any camera request owns the port, even one that is then dropped.
  assign w_clr_we       = (r_state == ST_CLEAR) && !cam_we;
  assign w_ptr_clr      = (r_state == ST_IDLE) && clr_start;

  clear_addr_gen #(
    .AW   (AW),
    .LAST (IMA_SIZE - 1)
  ) u_clear_addr_gen (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_ptr_clr),
    .i_en  (w_clr_we),
    .o_ptr (w_ptr),
    .o_tc  (w_tc)
  );

  // NOTE: every register here uses <= so all of them see pre-edge values;
  // a blocking update would leak into later reads within the same block.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_color_q  <= '0;
      r_clr_busy <= 1'b0;
      r_clr_done <= 1'b0;
      r_oob_flag <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else begin
      r_clr_busy <= (r_state != ST_IDLE);
      r_clr_done <= (r_state == ST_DONE);

      if (cam_we && !w_cam_in_range) begin
        r_oob_flag <= 1'b1;
      end

      // Address/data hold their last value whenever no write is issued.
      if (cam_we && w_cam_in_range) begin
        r_mem_we   <= 1'b1;
        r_mem_addr <= cam_addr;
        r_mem_data <= cam_data;
      end else if (w_clr_we) begin
        r_mem_we   <= 1'b1;
        r_mem_addr <= w_ptr;
        r_mem_data <= r_color_q;
      end else begin
        r_mem_we   <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (clr_start) begin
            r_color_q <= clr_color;
            r_state   <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (w_clr_we && w_tc) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign clr_busy = r_clr_busy;
  assign clr_done = r_clr_done;
  assign oob_flag = r_oob_flag;
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;

endmodule

// File: tb/tb_buffer_write_scheduler.sv
// Randomised scoreboard bench for buffer_write_scheduler: a cycle-numbered
// reference model queues the expected outputs, a negedge monitor compares them.
module tb_buffer_write_scheduler;

  localparam int SIZE = 160 * 120;

  typedef struct packed {
    logic        we;
    logic [14:0] addr;
    logic [11:0] data;
    logic        busy;
    logic        done;
    logic        oob;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cam_we;
  logic [14:0] cam_addr;
  logic [11:0] cam_data;
  logic        clr_start;
  logic [11:0] clr_color;
  logic        clr_busy;
  logic        clr_done;
  logic        oob_flag;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [11:0] mem_data;

  buffer_write_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .cam_we    (cam_we),
    .cam_addr  (cam_addr),
    .cam_data  (cam_data),
    .clr_start (clr_start),
    .clr_color (clr_color),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .oob_flag  (oob_flag),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Reference model: the clear is described by the cycle it was accepted,
  // the next address still to fill and the cycle its done pulse is due.
  longint      cyc        = 0;
  bit          m_clearing = 1'b0;
  longint      m_accept   = 0;
  longint      m_done_cyc = -1;
  int          m_next     = 0;
  logic [11:0] m_color    = '0;
  logic        m_oob      = 1'b0;
  logic [14:0] m_addr     = '0;
  logic [11:0] m_data     = '0;

  task automatic check(input string name, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got we=%b addr=%0d data=%h busy=%b done=%b oob=%b, expected we=%b addr=%0d data=%h busy=%b done=%b oob=%b",
               name, $time, act.we, act.addr, act.data, act.busy, act.done, act.oob,
               exp.we, exp.addr, exp.data, exp.busy, exp.done, exp.oob);
    end
  endtask

  // One clock cycle of stimulus; the expected outputs one cycle later are queued.
  task automatic step(input logic rs, input logic we, input logic [14:0] a,
                      input logic [11:0] d, input logic st, input logic [11:0] col);
    exp_t e;
    bit   acc;
    reset     = rs;
    cam_we    = we;
    cam_addr  = a;
    cam_data  = d;
    clr_start = st;
    clr_color = col;
    e = '0;
    if (!rs) begin
      m_clearing = 1'b0;
      m_done_cyc = -1;
      m_next     = 0;
      m_color    = '0;
      m_oob      = 1'b0;
      m_addr     = '0;
      m_data     = '0;
    end else begin
      acc    = st && !m_clearing && (cyc >= m_done_cyc);
      e.busy = (m_clearing && cyc > m_accept) || (cyc + 1 == m_done_cyc);
      e.done = (cyc + 1 == m_done_cyc);
      if (we) begin
        if (int'(a) < SIZE) begin
          e.we   = 1'b1;
          m_addr = a;
          m_data = d;
        end else begin
          m_oob = 1'b1;
        end
      end else if (m_clearing && cyc > m_accept) begin
        e.we   = 1'b1;
        m_addr = 15'(m_next);
        m_data = m_color;
        m_next++;
        if (m_next == SIZE) begin
          m_clearing = 1'b0;
          m_done_cyc = cyc + 2;
        end
      end
      if (acc) begin
        m_clearing = 1'b1;
        m_accept   = cyc;
        m_color    = col;
        m_next     = 0;
      end
      e.addr = m_addr;
      e.data = m_data;
      e.oob  = m_oob;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 15'd0, 12'($urandom), 1'b0, 12'($urandom));
  endtask

  // Start a clear; camera hits every cam_period cycles (0 = none), a second
  // clr_start with another colour mid-way, optional early stop at a fill count.
  task automatic run_clear(input logic [11:0] col, input int cam_period, input int stop_at);
    logic cw;
    step(1'b1, 1'b0, 15'd0, 12'd0, 1'b1, col);
    for (int i = 0; i < 40000 && m_clearing; i++) begin
      if (stop_at >= 0 && m_next == stop_at) break;
      cw = (cam_period > 0) && ((i % cam_period) == 2);
      step(1'b1, cw, cw ? 15'($urandom_range(0, SIZE - 1)) : 15'd100,
           12'($urandom), (i == 777), 12'h00F);
    end
    if (stop_at < 0) idle(4);
  endtask

  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{we: mem_we, addr: mem_addr, data: mem_data,
            busy: clr_busy, done: clr_done, oob: oob_flag};
      check("outputs", a, e);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with camera requests active, then a first forwarded write.
    repeat (3) step(1'b0, 1'b1, 15'd5, 12'hABC, 1'b0, 12'h000);
    step(1'b1, 1'b1, 15'd5, 12'hABC, 1'b0, 12'h000);
    idle(3);

    // Random in-range capture traffic while idle.
    for (int i = 0; i < 200; i++)
      step(1'b1, 1'($urandom), 15'($urandom_range(0, SIZE - 1)), 12'($urandom), 1'b0, 12'h000);

    // Clear interrupted by reset after 5000 fills, then a fresh full clear.
    run_clear(12'h3C3, 0, 5000);
    step(1'b0, 1'b0, 15'd0, 12'd0, 1'b0, 12'd0);
    idle(3);
    run_clear(12'h0F0, 0, -1);

    // Clear with camera contention every third cycle.
    run_clear(12'hA5A, 3, -1);

    // Out-of-bounds capture: black word, top of the address space, then a good write.
    step(1'b1, 1'b1, 15'd19200, 12'hFFF, 1'b0, 12'd0);
    step(1'b1, 1'b1, 15'd32767, 12'h123, 1'b0, 12'd0);
    idle(2);
    step(1'b1, 1'b1, 15'd19199, 12'h456, 1'b0, 12'd0);
    idle(3);
    step(1'b0, 1'b0, 15'd0, 12'd0, 1'b0, 12'd0);
    idle(3);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
